// File: rtl/bram_pkg.sv
// Shared types and width helpers for the simple-dual-port BRAM controller and its array.
package bram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Width codes shared with the BRAM map cells; MODE_NONE marks an unsupported width.
    localparam logic [2:0] MODE_NONE = 3'b000;
    localparam logic [2:0] MODE_1    = 3'b101;
    localparam logic [2:0] MODE_2    = 3'b110;
    localparam logic [2:0] MODE_4    = 3'b100;
    localparam logic [2:0] MODE_9    = 3'b001;
    localparam logic [2:0] MODE_18   = 3'b010;
    localparam logic [2:0] MODE_36   = 3'b011;

    localparam int ARRAY_BITS = 36864;

    function automatic logic [2:0] mode_of(input int dw);
        case (dw)
            1:       return MODE_1;
            2:       return MODE_2;
            4:       return MODE_4;
            8, 9:    return MODE_9;
            16, 18:  return MODE_18;
            32, 36:  return MODE_36;
            default: return MODE_NONE;
        endcase
    endfunction

    function automatic bit width_legal(input int dw);
        return mode_of(dw) != MODE_NONE;
    endfunction

    function automatic int lane_width(input int dw);
        if (dw == 9 || dw == 18 || dw == 36) return 9;
        if (dw < 8) return dw;
        return 8;
    endfunction

    function automatic int be_width(input int dw);
        return dw / lane_width(dw);
    endfunction

endpackage

// File: rtl/bram_sdp_array.sv
// Behavioural one-write one-read synchronous array with per-lane write enables.
module bram_sdp_array
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                            clk,
    input  logic                            we,
    input  logic [ADDR_WIDTH-1:0]           waddr,
    input  logic [DATA_WIDTH-1:0]           wdata,
    input  logic [be_width(DATA_WIDTH)-1:0] wbe,
    input  logic                            re,
    input  logic [ADDR_WIDTH-1:0]           raddr,
    output logic [DATA_WIDTH-1:0]           rdata
);

    localparam int LANE_W = lane_width(DATA_WIDTH);
    localparam int BE_W   = be_width(DATA_WIDTH);
    localparam int DEPTH  = 1 << ADDR_WIDTH;

    // NOTE: storage and its read register have no reset; a reset would keep them out of block RAM.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // A read of the address being written returns the pre-write word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < BE_W; k++) begin
                if (wbe[k]) mem_q[waddr][k*LANE_W +: LANE_W] <= wdata[k*LANE_W +: LANE_W];
            end
        end
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bram_sdp_ctrl.sv
// Simple-dual-port BRAM controller: post-reset clear, byte-lane writes, read-during-write
// bypass and an optional output register in front of a behavioural block-RAM array.
module bram_sdp_ctrl
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH   = 18,
    parameter int ADDR_WIDTH   = 10,
    parameter int OUT_REG      = 1,
    parameter int RDW_NEW      = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic                            WEN,
    input  logic [ADDR_WIDTH-1:0]           WADDR,
    input  logic [DATA_WIDTH-1:0]           WDATA,
    input  logic [be_width(DATA_WIDTH)-1:0] WBE,
    input  logic                            REN,
    input  logic [ADDR_WIDTH-1:0]           RADDR,
    output logic [DATA_WIDTH-1:0]           RDATA,
    output logic                            RVALID,
    output logic                            INIT_BUSY
);

    localparam int LANE_W = lane_width(DATA_WIDTH);
    localparam int BE_W   = be_width(DATA_WIDTH);
    localparam int DEPTH  = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam state_e RST_STATE = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;

    if (!width_legal(DATA_WIDTH)) begin : g_bad_width
        $error("bram_sdp_ctrl: DATA_WIDTH %0d is not a supported width", DATA_WIDTH);
    end
    if (DATA_WIDTH * DEPTH > ARRAY_BITS) begin : g_bad_depth
        $error("bram_sdp_ctrl: %0d x %0d exceeds one block RAM", DATA_WIDTH, DEPTH);
    end

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    busy;
    logic                    wr_fire, rd_fire, collide;

    logic                    arr_we;
    logic [ADDR_WIDTH-1:0]   arr_waddr;
    logic [DATA_WIDTH-1:0]   arr_wdata;
    logic [BE_W-1:0]         arr_wbe;
    logic [DATA_WIDTH-1:0]   arr_rdata;

    logic [DATA_WIDTH-1:0]   wmask;
    logic                    valid1_q, valid1_d;
    logic                    byp_hit_q, byp_hit_d;
    logic [DATA_WIDTH-1:0]   byp_data_q, byp_data_d;
    logic [DATA_WIDTH-1:0]   byp_mask_q, byp_mask_d;
    logic [DATA_WIDTH-1:0]   s1_data;

    assign busy      = (state_q == ST_CLEAR);
    assign INIT_BUSY = busy;
    assign wr_fire   = WEN & ~busy;
    assign rd_fire   = REN & ~busy;
    assign collide   = (RDW_NEW != 0) && wr_fire && rd_fire && (WADDR == RADDR);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) state_d = ST_READY;
        end
    end

    // The clear sequencer owns the write port while busy.
    always_comb begin
        arr_we    = busy | wr_fire;
        arr_waddr = busy ? cnt_q : WADDR;
        arr_wdata = busy ? '0 : WDATA;
        arr_wbe   = busy ? {BE_W{1'b1}} : WBE;
    end

    always_comb begin
        wmask = '0;
        for (int k = 0; k < BE_W; k++) begin
            wmask[k*LANE_W +: LANE_W] = {LANE_W{WBE[k]}};
        end
    end

    always_comb begin
        valid1_d   = rd_fire;
        byp_hit_d  = byp_hit_q;
        byp_data_d = byp_data_q;
        byp_mask_d = byp_mask_q;
        if (rd_fire) begin
            byp_hit_d  = collide;
            byp_data_d = WDATA;
            byp_mask_d = wmask;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= RST_STATE;
            cnt_q      <= '0;
            valid1_q   <= 1'b0;
            byp_hit_q  <= 1'b0;
            byp_data_q <= '0;
            byp_mask_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            valid1_q   <= valid1_d;
            byp_hit_q  <= byp_hit_d;
            byp_data_q <= byp_data_d;
            byp_mask_q <= byp_mask_d;
        end
    end

    bram_sdp_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (CLK),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .wbe   (arr_wbe),
        .re    (rd_fire),
        .raddr (RADDR),
        .rdata (arr_rdata)
    );

    // Same-address collision: enabled lanes come from the write, the rest from the array.
    assign s1_data = byp_hit_q ? ((arr_rdata & ~byp_mask_q) | (byp_data_q & byp_mask_q))
                               : arr_rdata;

    if (OUT_REG != 0) begin : g_out_reg
        logic                  valid2_q;
        logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

        always_comb begin
            rdata_d = valid1_q ? s1_data : rdata_q;
        end

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                valid2_q <= 1'b0;
                rdata_q  <= '0;
            end else begin
                valid2_q <= valid1_q;
                rdata_q  <= rdata_d;
            end
        end

        assign RDATA  = rdata_q;
        assign RVALID = valid2_q;
    end else begin : g_no_out_reg
        // The array register cannot be reset, so its word is masked until the first read lands.
        logic seen_q, seen_d;

        always_comb begin
            seen_d = seen_q | rd_fire;
        end

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) seen_q <= 1'b0;
            else        seen_q <= seen_d;
        end

        assign RDATA  = seen_q ? s1_data : '0;
        assign RVALID = valid1_q;
    end

endmodule
